// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate format tags, opcodes and buffer entry type for imm_gen_pipe
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } imm_fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Entries carry the widest immediate; narrower builds use the low XLEN bits.
    localparam int IMM_W = 64;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        imm_fmt_t         fmt;
        logic             illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_if.sv
// rtl/imm_gen_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    imm_fmt_t        out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational immediate decoder; IMMGEN_CSR_EN enables FMT_Z for CSR*I
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] inst,
    output imm_entry_t  res
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [IMM_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        res.imm     = '0;
        res.fmt     = FMT_NONE;
        res.illegal = 1'b0;
        if (inst[1:0] != 2'b11) begin
            res.illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LUI, OP_AUIPC: begin
                    res.fmt = FMT_U;
                    res.imm = imm_u;
                end
                OP_JAL: begin
                    res.fmt = FMT_J;
                    res.imm = imm_j;
                end
                OP_JALR, OP_LOAD: begin
                    res.fmt = FMT_I;
                    res.imm = imm_i;
                end
                OP_IMM: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        res.fmt = FMT_SH;
                        if (XLEN == 64) begin
                            res.imm = {58'b0, inst[25:20]};
                        end else begin
                            // RV32 shamt is 5 bits; a set bit 25 is a reserved encoding
                            res.imm     = {59'b0, inst[24:20]};
                            res.illegal = inst[25];
                        end
                    end else begin
                        res.fmt = FMT_I;
                        res.imm = imm_i;
                    end
                end
                OP_STORE: begin
                    res.fmt = FMT_S;
                    res.imm = imm_s;
                end
                OP_BRANCH: begin
                    res.fmt = FMT_B;
                    res.imm = imm_b;
                end
                OP_OP, OP_FENCE: begin
                    res.fmt = FMT_NONE;
                end
                OP_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
                    if (funct3[2]) begin
                        res.fmt = FMT_Z;
                        res.imm = {59'b0, inst[19:15]};
                    end
`endif
                end
                default: begin
                    res.illegal = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - decode-stage immediate generator with 2-entry skid buffer and flush
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    imm_gen_if.slave bus
);
    imm_entry_t dec_e, main_e, skid_e;
    logic       main_v, skid_v;
    logic       accept, drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst (bus.in_inst),
        .res  (dec_e)
    );

    // in_ready comes straight from the skid valid flop, so it is registered.
    assign bus.in_ready    = ~skid_v;
    assign accept          = bus.in_valid && ~skid_v && ~flush;
    assign drain           = main_v && bus.out_ready;

    assign bus.out_valid   = main_v;
    assign bus.out_imm     = main_e.imm[XLEN-1:0];
    assign bus.out_fmt     = main_e.fmt;
    assign bus.out_illegal = main_e.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_e <= '0;
            skid_e <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain && skid_v) begin
            main_e <= skid_e;
            skid_v <= 1'b0;
        end else if (accept && (!main_v || drain)) begin
            main_e <= dec_e;
            main_v <= 1'b1;
        end else if (accept) begin
            skid_e <= dec_e;
            skid_v <= 1'b1;
        end else if (drain) begin
            main_v <= 1'b0;
        end
    end

    generate
        if (XLEN < IMM_W) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^main_e.imm[IMM_W-1:XLEN];
        end
    endgenerate
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed bench for imm_gen_pipe at XLEN 32 and 64; honours IMMGEN_CSR_EN
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    imm_gen_if #(.XLEN(32)) b32 ();
    imm_gen_if #(.XLEN(64)) b64 ();

    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] i);
        b32.in_valid = v;
        b32.in_inst  = i;
        b64.in_valid = v;
        b64.in_inst  = i;
    endtask

    task automatic set_ready(input logic r);
        b32.out_ready = r;
        b64.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " out_valid"}, 64'(b32.out_valid), 64'd0);
        chk({tag, " in_ready"},  64'(b32.in_ready),  64'd1);
        chk({tag, " imm"},       64'(b32.out_imm),   64'd0);
        chk({tag, " fmt"},       64'(b32.out_fmt),   64'(FMT_NONE));
        chk({tag, " illegal"},   64'(b32.out_illegal), 64'd0);
        chk({tag, " imm64"},     b64.out_imm,        64'd0);
    endtask

    logic [31:0] vin  [12];
    logic [63:0] e32  [12];
    logic [63:0] e64  [12];
    imm_fmt_t    efmt [12];
    logic        il32 [12];
    logic        il64 [12];
    logic [31:0] sin  [4];
    logic [63:0] got  [4];
    imm_fmt_t    csr_fmt;
    logic [63:0] csr_imm;
    int          idx, n, seen;
    logic        acc;

    initial begin
`ifdef IMMGEN_CSR_EN
        csr_fmt = FMT_Z;
        csr_imm = 64'd15;
`else
        csr_fmt = FMT_NONE;
        csr_imm = 64'd0;
`endif
        vin  = '{32'h8000006F, 32'hFE112E23, 32'hFE000EE3, 32'hFE000E63, 32'h800002B7, 32'h03F09093,
                 32'h0000007F, 32'h0057D073, 32'hFFC12083, 32'h002081B3, 32'h00000001, 32'h40515093};
        e32  = '{64'hFFF00000, 64'hFFFFFFFC, 64'hFFFFFFFC, 64'hFFFFF7FC, 64'h80000000, 64'h1F,
                 64'h0, csr_imm, 64'hFFFFFFFC, 64'h0, 64'h0, 64'h5};
        e64  = '{64'hFFFFFFFFFFF00000, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFF7FC,
                 64'hFFFFFFFF80000000, 64'h3F, 64'h0, csr_imm, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h5};
        efmt = '{FMT_J, FMT_S, FMT_B, FMT_B, FMT_U, FMT_SH, FMT_NONE, csr_fmt, FMT_I, FMT_NONE, FMT_NONE, FMT_SH};
        il32 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        il64 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sin  = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0);
        set_ready(1'b1);
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // back-to-back directed vectors, one per cycle, drain every cycle
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, vin[k]);
            tick();
            chk($sformatf("v%0d valid32", k), 64'(b32.out_valid), 64'd1);
            chk($sformatf("v%0d valid64", k), 64'(b64.out_valid), 64'd1);
            chk($sformatf("v%0d imm32", k),   64'(b32.out_imm),   e32[k]);
            chk($sformatf("v%0d imm64", k),   b64.out_imm,        e64[k]);
            chk($sformatf("v%0d fmt32", k),   64'(b32.out_fmt),   64'(efmt[k]));
            chk($sformatf("v%0d fmt64", k),   64'(b64.out_fmt),   64'(efmt[k]));
            chk($sformatf("v%0d ill32", k),   64'(b32.out_illegal), 64'(il32[k]));
            chk($sformatf("v%0d ill64", k),   64'(b64.out_illegal), 64'(il64[k]));
            chk($sformatf("v%0d in_ready", k), 64'(b32.in_ready), 64'd1);
        end
        drive(1'b0, 32'h0);
        tick();
        chk("stream end valid", 64'(b32.out_valid), 64'd0);

        // backpressure: consumer stalled from the first instruction
        set_ready(1'b0);
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(idx < 4, sin[idx < 4 ? idx : 3]);
            acc = b32.in_valid && b32.in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp accepts", 64'(idx), 64'd2);
        chk("bp in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp hold valid", 64'(b32.out_valid), 64'd1);
        chk("bp hold imm", 64'(b32.out_imm), 64'd1);
        set_ready(1'b1);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (b32.out_valid && b32.out_ready) begin
                got[n] = 64'(b32.out_imm);
                n++;
            end
            drive(idx < 4, sin[idx < 4 ? idx : 3]);
            acc = b32.in_valid && b32.in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp drained count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp order %0d", i), got[i], 64'(i + 1));
        drive(1'b0, 32'h0);
        chk("bp no duplicate", 64'(b32.out_valid), 64'd0);

        // flush with both entries full and input presented
        set_ready(1'b0);
        drive(1'b1, 32'h00700093);
        tick();
        drive(1'b1, 32'h00800093);
        tick();
        chk("pre-flush in_ready", 64'(b32.in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00900093);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("flush2 out_valid", 64'(b32.out_valid), 64'd0);
        chk("flush2 in_ready",  64'(b32.in_ready),  64'd1);

        // flush with one entry while the block could accept
        drive(1'b1, 32'h00A00093);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h00900093);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("flush1 out_valid", 64'(b32.out_valid), 64'd0);
        chk("flush1 in_ready",  64'(b32.in_ready),  64'd1);
        set_ready(1'b1);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (b32.out_valid) seen++;
        end
        chk("flushed never seen", 64'(seen), 64'd0);

        // asynchronous reset with both entries full
        set_ready(1'b0);
        drive(1'b1, 32'h00B00093);
        tick();
        drive(1'b1, 32'h00C00093);
        tick();
        drive(1'b0, 32'h0);
        chk("pre-rst valid", 64'(b32.out_valid), 64'd1);
        chk("pre-rst in_ready", 64'(b32.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async rst");
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        set_ready(1'b1);
        tick();
        tick();
        chk_reset_outputs("post rst");
        drive(1'b1, 32'h0057D073);
        tick();
        drive(1'b0, 32'h0);
        chk("post rst first valid", 64'(b32.out_valid), 64'd1);
        chk("post rst first imm",   64'(b32.out_imm),   csr_imm);
        chk("post rst first fmt",   64'(b32.out_fmt),   64'(csr_fmt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
